ch0re_hazard_ctrl: RTL and testbench

- Parametrised scoreboard hazard and forwarding controller for the ch0re in-order pipeline.
- Sits beside the decode stage. It tracks in-flight register writers per architectural register and produces issue, stall, kill and per-operand forwarding selects.
- Generalises the fixed EX/MEM bypass and single-slot post-jump disable of the current decoder to configurable forwarding depth, load latency and flush shadow.

---
 rtl/ch0re_hazard_ctrl_pkg.sv | 26 ++
 rtl/ch0re_hazard_ctrl_if.sv | 54 +++++
 rtl/ch0re_hazard_ctrl_sb_lookup.sv | 41 ++++
 rtl/ch0re_hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_ch0re_hazard_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ch0re_hazard_ctrl_pkg.sv
// Shared types for the ch0re hazard/forwarding controller: forwarding-select
// encoding, scoreboard entry layout and defaults.
package ch0re_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_SEL_REG = 2'd0,
    FWD_SEL_MEM = 2'd1,
    FWD_SEL_WB  = 2'd2
  } fwd_sel_e;

  // Age field is wide enough for any practical forwarding depth, so the entry
  // layout does not depend on the controller parameters.
  localparam int unsigned SB_AGE_W        = 8;
  localparam int unsigned FLUSH_SLOTS_DEF = 1;

  typedef struct packed {
    logic                valid;
    logic                is_load;
    logic [SB_AGE_W-1:0] age;
  } sb_entry_t;

  function automatic logic [SB_AGE_W-1:0] age_c(input int unsigned v);
    return SB_AGE_W'(v);
  endfunction

endpackage

// File: rtl/ch0re_hazard_ctrl_if.sv
// Decode-side handshake bundle for ch0re_hazard_ctrl; stats outputs exist only
// when CH0RE_HAZARD_STATS_EN is defined.
interface ch0re_hazard_ctrl_if #(
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned FWD_DEPTH = 2
);
    localparam int unsigned RW = $clog2(NUM_REGS);
    localparam int unsigned SW = $clog2(FWD_DEPTH + 1);

    logic          i_id_valid;
    logic [RW-1:0] i_id_rs1;
    logic [RW-1:0] i_id_rs2;
    logic          i_id_rs1_used;
    logic          i_id_rs2_used;
    logic [RW-1:0] i_id_rd;
    logic          i_id_wen;
    logic          i_id_is_load;
    logic          i_id_is_store;
    logic          i_flush;
    logic          o_issue;
    logic          o_stall;
    logic          o_kill;
    logic [SW-1:0] o_fwd_sel1;
    logic [SW-1:0] o_fwd_sel2;
    logic          o_store_rs2_late;
`ifdef CH0RE_HAZARD_STATS_EN
    logic [31:0]   o_stall_cycles;
    logic [31:0]   o_kill_cycles;

    modport master (
        output i_id_valid, i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
               i_id_rd, i_id_wen, i_id_is_load, i_id_is_store, i_flush,
        input  o_issue, o_stall, o_kill, o_fwd_sel1, o_fwd_sel2, o_store_rs2_late,
               o_stall_cycles, o_kill_cycles
    );
    modport slave (
        input  i_id_valid, i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
               i_id_rd, i_id_wen, i_id_is_load, i_id_is_store, i_flush,
        output o_issue, o_stall, o_kill, o_fwd_sel1, o_fwd_sel2, o_store_rs2_late,
               o_stall_cycles, o_kill_cycles
    );
`else
    modport master (
        output i_id_valid, i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
               i_id_rd, i_id_wen, i_id_is_load, i_id_is_store, i_flush,
        input  o_issue, o_stall, o_kill, o_fwd_sel1, o_fwd_sel2, o_store_rs2_late
    );
    modport slave (
        input  i_id_valid, i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
               i_id_rd, i_id_wen, i_id_is_load, i_id_is_store, i_flush,
        output o_issue, o_stall, o_kill, o_fwd_sel1, o_fwd_sel2, o_store_rs2_late
    );
`endif
endinterface

// File: rtl/ch0re_hazard_ctrl_sb_lookup.sv
// Per-operand scoreboard lookup: forwarding select, load-use stall and the
// late store-data forwarding flag for one source register.
module ch0re_hazard_ctrl_sb_lookup
    import ch0re_hazard_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned FWD_DEPTH = 2,
    parameter int unsigned LOAD_LAT  = 2
) (
    input  logic [$clog2(NUM_REGS)-1:0]    rs,
    input  logic                           used,
    input  logic                           store_data,
    input  sb_entry_t                      ent,
    output logic [$clog2(FWD_DEPTH+1)-1:0] sel,
    output logic                           stall,
    output logic                           late
);
    localparam int unsigned SW = $clog2(FWD_DEPTH + 1);
    localparam logic [SB_AGE_W-1:0] LAT    = age_c(LOAD_LAT);
    localparam logic [SB_AGE_W-1:0] LAT_M1 = age_c(LOAD_LAT - 1);
    localparam logic [SB_AGE_W-1:0] ONE    = age_c(1);

    always_comb begin
        sel   = '0;
        stall = 1'b0;
        late  = 1'b0;
        if (used && rs != '0 && ent.valid) begin
            sel = SW'(ent.age);
            if (ent.is_load && ent.age < LAT) begin
                // Store data is consumed a stage later, so one cycle less of load latency suffices.
                if (store_data && ent.age == LAT_M1) begin
                    late = 1'b1;
                    sel  = SW'(ent.age + ONE);
                end else begin
                    stall = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ch0re_hazard_ctrl.sv
// Scoreboard hazard and forwarding controller beside the ch0re decode stage.
// Define CH0RE_HAZARD_STATS_EN to add saturating stall/kill cycle counters.
module ch0re_hazard_ctrl
    import ch0re_hazard_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 32,
    parameter int unsigned FWD_DEPTH   = 2,
    parameter int unsigned LOAD_LAT    = 2,
    parameter int unsigned FLUSH_SLOTS = FLUSH_SLOTS_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    ch0re_hazard_ctrl_if.slave hz
);
    localparam int unsigned RW = $clog2(NUM_REGS);
    localparam int unsigned SW = $clog2(FWD_DEPTH + 1);
    localparam int unsigned KW = (FLUSH_SLOTS > 1) ? $clog2(FLUSH_SLOTS) : 1;
    localparam logic [SB_AGE_W-1:0] AGE_RETIRE = age_c(FWD_DEPTH + 1);
    localparam logic [SB_AGE_W-1:0] AGE_ONE    = age_c(1);
    localparam logic [KW-1:0]       KILL_LOAD  = KW'(FLUSH_SLOTS - 1);

    sb_entry_t     sb [NUM_REGS];
    logic [KW-1:0] kill_cnt;
    logic          kill_act;
    logic          stall1, stall2;
    logic          rs1_late_unused, late2;
    logic [SW-1:0] sel1, sel2;
    logic          issue, stall, kill, sb_wr;

    ch0re_hazard_ctrl_sb_lookup #(
        .NUM_REGS (NUM_REGS),
        .FWD_DEPTH(FWD_DEPTH),
        .LOAD_LAT (LOAD_LAT)
    ) u_rs1_lookup (
        .rs        (hz.i_id_rs1),
        .used      (hz.i_id_rs1_used),
        .store_data(1'b0),
        .ent       (sb[hz.i_id_rs1]),
        .sel       (sel1),
        .stall     (stall1),
        .late      (rs1_late_unused)
    );

    ch0re_hazard_ctrl_sb_lookup #(
        .NUM_REGS (NUM_REGS),
        .FWD_DEPTH(FWD_DEPTH),
        .LOAD_LAT (LOAD_LAT)
    ) u_rs2_lookup (
        .rs        (hz.i_id_rs2),
        .used      (hz.i_id_rs2_used),
        .store_data(hz.i_id_is_store),
        .ent       (sb[hz.i_id_rs2]),
        .sel       (sel2),
        .stall     (stall2),
        .late      (late2)
    );

    always_comb begin
        kill_act = hz.i_flush || (kill_cnt != '0);
        kill     = 1'b0;
        stall    = 1'b0;
        issue    = 1'b0;
        if (hz.i_id_valid) begin
            kill  = kill_act;
            stall = !kill_act && (stall1 || stall2);
            issue = !kill_act && !(stall1 || stall2);
        end
        sb_wr = issue && hz.i_id_wen && (hz.i_id_rd != '0);
    end

    assign hz.o_issue          = issue;
    assign hz.o_stall          = stall;
    assign hz.o_kill           = kill;
    assign hz.o_fwd_sel1       = sel1;
    assign hz.o_fwd_sel2       = sel2;
    assign hz.o_store_rs2_late = late2;

    // A fresh issue overrides the aging/retire of the same entry in that cycle.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_sb
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sb[g] <= '0;
            end else if (sb_wr && hz.i_id_rd == RW'(g)) begin
                sb[g] <= '{valid: 1'b1, is_load: hz.i_id_is_load, age: AGE_ONE};
            end else if (sb[g].valid) begin
                if (sb[g].age + AGE_ONE == AGE_RETIRE) begin
                    sb[g] <= '0;
                end else begin
                    sb[g].age <= sb[g].age + AGE_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kill_cnt <= '0;
        end else if (hz.i_flush) begin
            kill_cnt <= KILL_LOAD;
        end else if (kill_cnt != '0) begin
            kill_cnt <= kill_cnt - 1'b1;
        end
    end

`ifdef CH0RE_HAZARD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hz.o_stall_cycles <= '0;
            hz.o_kill_cycles  <= '0;
        end else begin
            if (stall && hz.o_stall_cycles != '1) begin
                hz.o_stall_cycles <= hz.o_stall_cycles + 32'd1;
            end
            if (kill && hz.o_kill_cycles != '1) begin
                hz.o_kill_cycles <= hz.o_kill_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ch0re_hazard_ctrl.sv
// Self-checking bench: two configurations of ch0re_hazard_ctrl driven in
// lockstep and compared against a rule-level scoreboard model.
module tb_ch0re_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ch0re_hazard_ctrl_if #(.NUM_REGS(32), .FWD_DEPTH(2)) ifa ();
    ch0re_hazard_ctrl_if #(.NUM_REGS(32), .FWD_DEPTH(3)) ifb ();

    ch0re_hazard_ctrl #(.NUM_REGS(32), .FWD_DEPTH(2), .LOAD_LAT(2), .FLUSH_SLOTS(3))
        u_dut_a (.clk(clk), .rst_n(rst_n), .hz(ifa));
    ch0re_hazard_ctrl #(.NUM_REGS(32), .FWD_DEPTH(3), .LOAD_LAT(3), .FLUSH_SLOTS(1))
        u_dut_b (.clk(clk), .rst_n(rst_n), .hz(ifb));

    int n_cmp = 0;
    int n_err = 0;

    // Configuration of each DUT: forwarding depth, load latency, flush slots.
    int    fd [2] = '{2, 3};
    int    ll [2] = '{2, 3};
    int    fs [2] = '{3, 1};
    string nm [2] = '{"A", "B"};

    // Reference state: per-register in-flight writer, kill slots remaining.
    bit mv [2][32];
    bit ml [2][32];
    int ma [2][32];
    int mk [2];
    int mst [2];
    int mkc [2];

    int e_issue [2], e_stall [2], e_kill [2], e_sel1 [2], e_sel2 [2], e_late [2];
    logic [31:0] ob_issue [2], ob_stall [2], ob_kill [2], ob_sel1 [2], ob_sel2 [2], ob_late [2];
    logic [31:0] ob_scyc [2], ob_kcyc [2];

    logic       v, u1, u2, we, ld, st, fl;
    logic [4:0] r1, r2, rd;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 32; r++) begin
                mv[c][r] = 1'b0;
                ml[c][r] = 1'b0;
                ma[c][r] = 0;
            end
            mk[c]  = 0;
            mst[c] = 0;
            mkc[c] = 0;
        end
    endfunction

    function automatic void look(input int c, input logic [4:0] r, input logic u, input logic sd,
                                 output int sel, output bit stl, output bit lt);
        sel = 0;
        stl = 1'b0;
        lt  = 1'b0;
        if (u && r != 5'd0 && mv[c][r]) begin
            sel = ma[c][r];
            if (ml[c][r] && ma[c][r] < ll[c]) begin
                if (sd && ma[c][r] == ll[c] - 1) begin
                    lt  = 1'b1;
                    sel = ma[c][r] + 1;
                end else begin
                    stl = 1'b1;
                end
            end
        end
    endfunction

    function automatic void model_eval();
        for (int c = 0; c < 2; c++) begin
            bit st1, st2, lt1, lt2, kil;
            look(c, r1, u1, 1'b0, e_sel1[c], st1, lt1);
            look(c, r2, u2, st, e_sel2[c], st2, lt2);
            kil        = fl || (mk[c] > 0);
            e_kill[c]  = (v && kil) ? 1 : 0;
            e_stall[c] = (v && !kil && (st1 || st2)) ? 1 : 0;
            e_issue[c] = (v && !kil && !(st1 || st2)) ? 1 : 0;
            e_late[c]  = lt2 ? 1 : 0;
        end
    endfunction

    function automatic void model_update();
        for (int c = 0; c < 2; c++) begin
            for (int r = 1; r < 32; r++) begin
                if (mv[c][r]) begin
                    ma[c][r]++;
                    if (ma[c][r] > fd[c]) mv[c][r] = 1'b0;
                end
            end
            if (e_issue[c] == 1 && we && rd != 5'd0) begin
                mv[c][rd] = 1'b1;
                ma[c][rd] = 1;
                ml[c][rd] = ld;
            end
            mst[c] += e_stall[c];
            mkc[c] += e_kill[c];
            mk[c] = fl ? fs[c] - 1 : ((mk[c] > 0) ? mk[c] - 1 : 0);
        end
    endfunction

    task automatic drive();
        ifa.i_id_valid = v;  ifa.i_id_rs1 = r1;  ifa.i_id_rs2 = r2;  ifa.i_id_rd = rd;
        ifa.i_id_rs1_used = u1;  ifa.i_id_rs2_used = u2;  ifa.i_id_wen = we;
        ifa.i_id_is_load = ld;  ifa.i_id_is_store = st;  ifa.i_flush = fl;
        ifb.i_id_valid = v;  ifb.i_id_rs1 = r1;  ifb.i_id_rs2 = r2;  ifb.i_id_rd = rd;
        ifb.i_id_rs1_used = u1;  ifb.i_id_rs2_used = u2;  ifb.i_id_wen = we;
        ifb.i_id_is_load = ld;  ifb.i_id_is_store = st;  ifb.i_flush = fl;
    endtask

    task automatic sample_and_check();
        ob_issue[0] = 32'(ifa.o_issue);  ob_stall[0] = 32'(ifa.o_stall);  ob_kill[0] = 32'(ifa.o_kill);
        ob_sel1[0] = 32'(ifa.o_fwd_sel1);  ob_sel2[0] = 32'(ifa.o_fwd_sel2);
        ob_late[0] = 32'(ifa.o_store_rs2_late);
        ob_issue[1] = 32'(ifb.o_issue);  ob_stall[1] = 32'(ifb.o_stall);  ob_kill[1] = 32'(ifb.o_kill);
        ob_sel1[1] = 32'(ifb.o_fwd_sel1);  ob_sel2[1] = 32'(ifb.o_fwd_sel2);
        ob_late[1] = 32'(ifb.o_store_rs2_late);
        model_eval();
        for (int c = 0; c < 2; c++) begin
            chk({nm[c], ".issue"}, ob_issue[c], e_issue[c]);
            chk({nm[c], ".stall"}, ob_stall[c], e_stall[c]);
            chk({nm[c], ".kill"},  ob_kill[c],  e_kill[c]);
            chk({nm[c], ".sel1"},  ob_sel1[c],  e_sel1[c]);
            chk({nm[c], ".sel2"},  ob_sel2[c],  e_sel2[c]);
            chk({nm[c], ".late"},  ob_late[c],  e_late[c]);
        end
`ifdef CH0RE_HAZARD_STATS_EN
        ob_scyc[0] = ifa.o_stall_cycles;  ob_kcyc[0] = ifa.o_kill_cycles;
        ob_scyc[1] = ifb.o_stall_cycles;  ob_kcyc[1] = ifb.o_kill_cycles;
        for (int c = 0; c < 2; c++) begin
            chk({nm[c], ".stall_cycles"}, ob_scyc[c], mst[c]);
            chk({nm[c], ".kill_cycles"},  ob_kcyc[c], mkc[c]);
        end
`endif
    endtask

    task automatic step(input logic iv, input logic [4:0] ir1, input logic iu1,
                        input logic [4:0] ir2, input logic iu2, input logic [4:0] ird,
                        input logic iwe, input logic ild, input logic ist, input logic ifl);
        @(negedge clk);
        v = iv;  r1 = ir1;  u1 = iu1;  r2 = ir2;  u2 = iu2;
        rd = ird;  we = iwe;  ld = ild;  st = ist;  fl = ifl;
        drive();
        #1;
        sample_and_check();
        @(posedge clk);
        if (rst_n) model_update();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        idle(2);
        #2 rst_n = 1'b1;

        // ALU producer, then readers one, two and three cycles later
        step(1, 1, 1, 0, 0, 5, 1, 0, 0, 0);
        step(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        chk("alu_sel1_age1", ob_sel1[0], 1);
        chk("alu_nostall", ob_stall[0], 0);
        step(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        chk("alu_sel1_age2", ob_sel1[0], 2);
        step(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        chk("alu_sel1_retired", ob_sel1[0], 0);
        idle(4);

        // Load-use: one stall on A, two on B
        step(1, 2, 1, 0, 0, 7, 1, 1, 0, 0);
        step(1, 7, 1, 0, 1, 8, 1, 0, 0, 0);
        chk("lduse_stall_a", ob_stall[0], 1);
        chk("lduse_stall_b", ob_stall[1], 1);
        step(1, 7, 1, 0, 1, 8, 1, 0, 0, 0);
        chk("lduse_issue_a", ob_issue[0], 1);
        chk("lduse_sel1_a", ob_sel1[0], 2);
        step(1, 7, 1, 0, 1, 8, 1, 0, 0, 0);
        chk("lduse_issue_b", ob_issue[1], 1);
        chk("lduse_sel1_b", ob_sel1[1], 3);
        idle(4);

        // Load then store of the loaded value
        step(1, 2, 1, 0, 0, 7, 1, 1, 0, 0);
        step(1, 2, 1, 7, 1, 0, 0, 0, 1, 0);
        chk("st_late_nostall_a", ob_stall[0], 0);
        chk("st_late_a", ob_late[0], 1);
        chk("st_late_sel2_a", ob_sel2[0], 2);
        chk("st_early_stall_b", ob_stall[1], 1);
        step(1, 2, 1, 7, 1, 0, 0, 0, 1, 0);
        chk("st_late_b", ob_late[1], 1);
        chk("st_late_sel2_b", ob_sel2[1], 3);
        chk("st_late_nostall_b", ob_stall[1], 0);
        idle(4);

        // Newest of two writers to x9 wins (older one is a load)
        step(1, 0, 0, 0, 0, 9, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
        step(1, 1, 1, 9, 1, 11, 1, 0, 0, 0);
        chk("waw_sel2_a", ob_sel2[0], 1);
        chk("waw_nostall_b", ob_stall[1], 0);
        idle(4);

        // Flush coincident with load-use; killed writer must not touch x10
        step(1, 2, 1, 0, 0, 7, 1, 1, 0, 0);
        step(1, 7, 1, 10, 1, 10, 1, 0, 0, 1);
        chk("flush_kill_a", ob_kill[0], 1);
        chk("flush_nostall_a", ob_stall[0], 0);
        chk("flush_noissue_a", ob_issue[0], 0);
        step(1, 7, 1, 10, 1, 10, 1, 0, 0, 0);
        chk("flush_kill2_a", ob_kill[0], 1);
        chk("flush_kill2_b", ob_kill[1], 0);
        step(1, 7, 1, 10, 1, 10, 1, 0, 0, 0);
        chk("flush_kill3_a", ob_kill[0], 1);
        step(1, 7, 1, 10, 1, 10, 1, 0, 0, 0);
        chk("flush_end_a", ob_kill[0], 0);
        chk("flush_sb_clean_a", ob_sel2[0], 0);
        idle(4);

        // Second flush on cycle 2 stretches the kill window to cycle 4
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reflush_kill4_a", ob_kill[0], 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reflush_end_a", ob_kill[0], 0);
        idle(3);

        // Asynchronous reset with a fresh entry in flight
        step(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        @(negedge clk);
        v = 1;  r1 = 5;  u1 = 1;  r2 = 0;  u2 = 0;  rd = 6;  we = 1;  ld = 0;  st = 0;  fl = 0;
        drive();
        #1;
        chk("prereset_stall_a", 32'(ifa.o_stall), 1);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        sample_and_check();
        chk("reset_sel1_a", ob_sel1[0], 0);
        chk("reset_stall_a", ob_stall[0], 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
        chk("postreset_issue_a", ob_issue[0], 1);
        chk("postreset_sel1_b", ob_sel1[1], 0);

        // Randomized traffic over a small register window to provoke hazards
        for (int i = 0; i < 500; i++) begin
            step(logic'($urandom_range(0, 9) != 0),
                 5'($urandom_range(0, 7)), logic'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), logic'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 3) == 0),
                 logic'($urandom_range(0, 15) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
